// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: top-level mode sequencer for the digital clock (setter ownership, alarm ring with timeout/stop)
// Ports:
//   clk, rst (async active-low)        clock and reset
//   sec_tick                           one-cycle pulse per second
//   sel/mode/inc/stop buttons          synchronous button levels
//   cur_*/alarm_*, alarm_on            current time, stored alarm, armed flag
//   set_time_ack, set_alarm_ack        setter finished levels
//   set_time_en, set_alarm_en          setter enables
//   mode_pulse, inc_pulse              one-cycle pulses to the active setter
//   alarm_ring                         buzzer drive
//   state                              NORMAL=0 SET_TIME=1 SET_ALARM=2 RINGING=3
module clock_mode_ctrl #(
  parameter int RING_SECS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       sel_button,
  input  logic       mode_button_in,
  input  logic       inc_button_in,
  input  logic       stop_button,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_on,
  input  logic       set_time_ack,
  input  logic       set_alarm_ack,
  output logic       set_time_en,
  output logic       set_alarm_en,
  output logic       mode_pulse,
  output logic       inc_pulse,
  output logic       alarm_ring,
  output logic [1:0] state
);
  localparam int CW = $clog2(RING_SECS + 1);
  typedef enum logic [1:0] {NORMAL, SET_TIME, SET_ALARM, RINGING} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sel_q, mode_q, inc_q, stop_q, tack_q, aack_q;
  logic sel_e, mode_e, inc_e, stop_e, tack_e, aack_e;
  logic match, timeout, setting, ten_d, aen_d, mp_d, ip_d, ring_d;
  assign sel_e   = sel_button & ~sel_q;
  assign mode_e  = mode_button_in & ~mode_q;
  assign inc_e   = inc_button_in & ~inc_q;
  assign stop_e  = stop_button & ~stop_q;
  assign tack_e  = set_time_ack & ~tack_q;
  assign aack_e  = set_alarm_ack & ~aack_q;
  assign match   = alarm_on & sec_tick & (cur_hours == alarm_hours) &
                   (cur_minutes == alarm_minutes) & (cur_seconds == 6'd0);
  assign timeout = sec_tick & (cnt_q == CW'(RING_SECS - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      NORMAL: begin
        cnt_d   = match ? '0 : cnt_q;
        state_d = match ? RINGING : sel_e ? SET_TIME : NORMAL;
      end
      SET_TIME:  state_d = tack_e ? NORMAL : sel_e ? SET_ALARM : SET_TIME;
      SET_ALARM: state_d = (aack_e | sel_e) ? NORMAL : SET_ALARM;
      default: begin
        cnt_d   = sec_tick ? cnt_q + 1'b1 : cnt_q;
        state_d = (stop_e | timeout) ? NORMAL : RINGING;
      end
    endcase
  end
  // pulses only reach a setter that stays in control this cycle
  assign setting = (state_q == SET_TIME) | (state_q == SET_ALARM);
  always_comb begin
    ten_d  = state_d == SET_TIME;
    aen_d  = state_d == SET_ALARM;
    ring_d = state_d == RINGING;
    mp_d   = mode_e & setting & (state_d == state_q);
    ip_d   = inc_e & setting & (state_d == state_q);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {sel_q, mode_q, inc_q, stop_q, tack_q, aack_q} <= '0;
      {set_time_en, set_alarm_en, mode_pulse, inc_pulse, alarm_ring} <= '0;
    end else begin
      {sel_q, mode_q, inc_q, stop_q, tack_q, aack_q} <=
        {sel_button, mode_button_in, inc_button_in, stop_button, set_time_ack, set_alarm_ack};
      {set_time_en, set_alarm_en, mode_pulse, inc_pulse, alarm_ring} <= {ten_d, aen_d, mp_d, ip_d, ring_d};
    end
  assign state = state_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: table-driven directed bench for clock_mode_ctrl (RING_SECS=3)
module tb_clock_mode_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic sec_tick, sel_button, mode_button_in, inc_button_in, stop_button;
  logic [4:0] cur_hours, alarm_hours;
  logic [5:0] cur_minutes, cur_seconds, alarm_minutes;
  logic alarm_on, set_time_ack, set_alarm_ack;
  logic set_time_en, set_alarm_en, mode_pulse, inc_pulse, alarm_ring;
  logic [1:0] state;
  int applied = 0, miscompares = 0;
  typedef struct {
    logic sel, mode, inc, stop, tick, tack, aack, aon;
    int   ts;
    logic [1:0] st;
    logic mp, ip;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  clock_mode_ctrl #(.RING_SECS(3)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .sel_button(sel_button),
    .mode_button_in(mode_button_in), .inc_button_in(inc_button_in), .stop_button(stop_button),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_on(alarm_on),
    .set_time_ack(set_time_ack), .set_alarm_ack(set_alarm_ack),
    .set_time_en(set_time_en), .set_alarm_en(set_alarm_en), .mode_pulse(mode_pulse),
    .inc_pulse(inc_pulse), .alarm_ring(alarm_ring), .state(state)
  );
  // ts: 0 = 07:31:00 (no match), 1 = 07:30:00 (match), 2 = 07:30:05 (seconds off)
  function automatic vec_t mk(logic s, m, i, p, t, ta, aa, ao, int ts, logic [1:0] st, logic mp, ip);
    vec_t v;
    v.sel = s; v.mode = m; v.inc = i; v.stop = p; v.tick = t; v.tack = ta; v.aack = aa; v.aon = ao;
    v.ts = ts; v.st = st; v.mp = mp; v.ip = ip;
    return v;
  endfunction
  task automatic drive(vec_t v);
    sel_button = v.sel; mode_button_in = v.mode; inc_button_in = v.inc; stop_button = v.stop;
    sec_tick = v.tick; set_time_ack = v.tack; set_alarm_ack = v.aack; alarm_on = v.aon;
    cur_hours = 5'd7;
    cur_minutes = (v.ts == 0) ? 6'd31 : 6'd30;
    cur_seconds = (v.ts == 2) ? 6'd5 : 6'd0;
  endtask
  task automatic chk(string name, logic [1:0] st, logic mp, ip);
    logic [6:0] got, exp;
    got = {state, set_time_en, set_alarm_en, mode_pulse, inc_pulse, alarm_ring};
    exp = {st, st == 2'd1, st == 2'd2, mp, ip, st == 2'd3};
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got st/ten/aen/mp/ip/ring=%b required %b", name, got, exp);
    end
  endtask
  initial begin
    alarm_hours = 5'd7; alarm_minutes = 6'd30;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    // s m i p t ta aa ao ts st mp ip
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,0)); // sel -> SET_TIME
    tv.push_back(mk(0,0,1,0,0,0,0,0,0,1,0,1)); // inc edge -> pulse
    tv.push_back(mk(0,0,1,0,0,0,0,0,0,1,0,0)); // held inc: no more pulses
    tv.push_back(mk(0,0,1,0,0,0,0,0,0,1,0,0));
    tv.push_back(mk(0,0,1,0,0,0,0,0,0,1,0,0));
    tv.push_back(mk(0,0,1,0,0,0,0,0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0));
    tv.push_back(mk(0,1,1,0,0,0,0,0,0,1,1,1)); // both pulses together
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0));
    tv.push_back(mk(0,1,0,0,1,0,0,1,1,1,1,0)); // match while setting ignored, mode forwarded
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0));
    tv.push_back(mk(1,0,0,0,0,0,1,0,0,2,0,0)); // sel -> SET_ALARM, ack already high
    tv.push_back(mk(0,0,0,0,0,0,1,0,0,2,0,0)); // held ack: stay
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,2,0,0));
    tv.push_back(mk(0,1,0,0,0,0,1,0,0,0,0,0)); // ack edge -> NORMAL, mode suppressed
    tv.push_back(mk(1,0,0,0,0,0,1,0,0,1,0,0)); // sel -> SET_TIME
    tv.push_back(mk(0,0,1,0,0,1,0,0,0,0,0,0)); // time ack edge -> NORMAL, inc suppressed
    tv.push_back(mk(1,0,0,0,0,1,0,0,0,1,0,0)); // re-enter with ack held
    tv.push_back(mk(0,0,0,0,0,1,0,0,0,1,0,0)); // held ack does not exit
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,2,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,2,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0)); // sel in SET_ALARM -> NORMAL
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,0,1,0,0,0)); // alarm_on=0: no ring
    tv.push_back(mk(0,0,0,0,0,0,0,1,1,0,0,0)); // no tick: no ring
    tv.push_back(mk(0,0,0,0,1,0,0,1,2,0,0,0)); // seconds != 0: no ring
    tv.push_back(mk(1,0,0,0,1,0,0,1,1,3,0,0)); // match beats sel -> RINGING
    tv.push_back(mk(0,0,0,0,0,0,0,1,0,3,0,0));
    tv.push_back(mk(1,1,1,0,0,0,0,1,0,3,0,0)); // sel/mode/inc ignored while ringing
    tv.push_back(mk(0,0,0,0,1,0,0,1,0,3,0,0)); // tick 1
    tv.push_back(mk(0,0,0,0,0,0,0,1,0,3,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,1,0,3,0,0)); // tick 2
    tv.push_back(mk(0,0,0,0,1,0,0,1,0,0,0,0)); // tick 3 -> timeout
    tv.push_back(mk(0,0,0,1,0,0,0,1,0,0,0,0)); // stop ignored in NORMAL
    tv.push_back(mk(0,0,0,0,1,0,0,1,1,3,0,0)); // ring again
    tv.push_back(mk(0,0,0,1,1,0,0,1,0,0,0,0)); // stop on first tick
    tv.push_back(mk(0,0,0,0,1,0,0,1,1,3,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,1,0,3,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,1,0,3,0,0));
    tv.push_back(mk(0,0,0,1,1,0,0,1,0,0,0,0)); // stop + timeout together
    tv.push_back(mk(0,0,0,0,1,0,0,1,1,3,0,0));
    tv.push_back(mk(0,0,0,1,0,0,0,1,0,0,0,0)); // stop without tick
    tv.push_back(mk(0,0,0,1,1,0,0,1,1,3,0,0)); // enter with stop held
    tv.push_back(mk(0,0,0,1,0,0,0,1,0,3,0,0)); // held stop: keep ringing
    tv.push_back(mk(0,0,0,0,0,0,0,1,0,3,0,0));
    tv.push_back(mk(0,0,0,1,0,0,0,1,0,0,0,0));
    #12;
    chk("reset", 2'd0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk) drive(tv[i]);
      @(posedge clk) #1;
      chk($sformatf("vec%0d", i), tv[i].st, tv[i].mp, tv[i].ip);
    end
    @(negedge clk) drive(mk(0,0,0,0,1,0,0,1,1,0,0,0));
    @(posedge clk) #1;
    chk("ring_before_rst", 2'd3, 1'b0, 1'b0);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    #2 rst = 1'b0;
    #1 chk("async_rst_ring", 2'd0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    chk("after_rst_ring", 2'd0, 1'b0, 1'b0);
    @(negedge clk) sel_button = 1'b1;
    @(negedge clk) sel_button = 1'b0;
    @(negedge clk) sel_button = 1'b1;
    @(posedge clk) #1;
    chk("alarm_before_rst", 2'd2, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 chk("async_rst_alarm", 2'd0, 1'b0, 1'b0);
    @(negedge clk) begin rst = 1'b1; sel_button = 1'b0; end
    @(posedge clk) #1;
    chk("after_rst_alarm", 2'd0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
